// File: rtl/dbus_peri_initiator_pkg.sv
// Shared data-bus definitions: initiator/peripheral bus structs, initiator FSM states
// and default placement of the peripheral window region.
package dbus_peri_initiator_pkg;

  localparam logic [31:0] DBUS_PERI_BASE_DEFAULT      = 32'h8000_0000;
  localparam int          DBUS_PERI_SPAN_LOG2_DEFAULT = 8;

  typedef struct packed {
    logic        req;
    logic [31:0] addr;
    logic [31:0] w_data;
    logic        w_en;
  } type_dbus2peri_s;

  typedef struct packed {
    logic        ack;
    logic [31:0] r_data;
  } type_peri2dbus_s;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RESP
  } type_dbus_init_state_e;

endpackage

// File: rtl/dbus_peri_initiator_addr_decode.sv
// Combinational address decode: maps a byte address onto one of NUM_PERI equal-sized
// peripheral windows starting at PERI_BASE, producing hit, slot index and one-hot select.
module dbus_peri_initiator_addr_decode
  import dbus_peri_initiator_pkg::*;
#(
  parameter int          NUM_PERI       = 4,
  parameter logic [31:0] PERI_BASE      = DBUS_PERI_BASE_DEFAULT,
  parameter int          PERI_SPAN_LOG2 = DBUS_PERI_SPAN_LOG2_DEFAULT,
  localparam int         IDX_W          = $clog2(NUM_PERI)
) (
  input  logic [31:0]         addr_i,
  output logic                hit_o,
  output logic [IDX_W-1:0]    idx_o,
  output logic [NUM_PERI-1:0] sel_o
);

  localparam logic [32:0] WIN_BYTES = 33'(NUM_PERI) << PERI_SPAN_LOG2;

  logic [31:0] off;

  // Wrapping subtraction turns addresses below the base into huge offsets, so one compare suffices.
  assign off   = addr_i - PERI_BASE;
  assign hit_o = ({1'b0, off} < WIN_BYTES);
  assign idx_o = off[PERI_SPAN_LOG2 +: IDX_W];

  always_comb begin
    sel_o = '0;
    if (hit_o) begin
      sel_o[idx_o] = 1'b1;
    end
  end

endmodule

// File: rtl/dbus_peri_initiator.sv
// Single-outstanding data-bus initiator from the LSU to NUM_PERI peripheral windows.
// Optional macro DBUS_TIMEOUT_EN adds a REQ-phase timeout that ends the transfer with a bus error.
module dbus_peri_initiator
  import dbus_peri_initiator_pkg::*;
#(
  parameter int          NUM_PERI       = 4,
  parameter logic [31:0] PERI_BASE      = DBUS_PERI_BASE_DEFAULT,
  parameter int          PERI_SPAN_LOG2 = DBUS_PERI_SPAN_LOG2_DEFAULT,
  parameter int          TIMEOUT_CYCLES = 255,
  localparam int         IDX_W          = $clog2(NUM_PERI)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  lsu_req_valid_i,
  output logic                  lsu_req_ready_o,
  input  logic [31:0]           lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  input  logic                  lsu_we_i,
  output logic                  lsu_rsp_valid_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  lsu_rsp_err_o,
  output type_dbus2peri_s       dbus2peri_o,
  output logic [NUM_PERI-1:0]   peri_sel_o,
  input  type_peri2dbus_s       peri2dbus_i [NUM_PERI]
);

  type_dbus_init_state_e state_q, state_d;
  type_dbus2peri_s       dbus_q, dbus_d;
  logic [NUM_PERI-1:0]   sel_q, sel_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic                  dec_hit;
  logic [IDX_W-1:0]      dec_idx;
  logic [NUM_PERI-1:0]   dec_sel;
  logic                  peri_ack;
  logic [31:0]           peri_rdata;

`ifdef DBUS_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  dbus_peri_initiator_addr_decode #(
    .NUM_PERI      (NUM_PERI),
    .PERI_BASE     (PERI_BASE),
    .PERI_SPAN_LOG2(PERI_SPAN_LOG2)
  ) u_addr_decode (
    .addr_i(lsu_addr_i),
    .hit_o (dec_hit),
    .idx_o (dec_idx),
    .sel_o (dec_sel)
  );

  // Only the addressed slot is listened to; acks from other slots are ignored.
  assign peri_ack   = peri2dbus_i[idx_q].ack;
  assign peri_rdata = peri2dbus_i[idx_q].r_data;

  always_comb begin
    state_d     = state_q;
    dbus_d      = dbus_q;
    sel_d       = sel_q;
    idx_d       = idx_q;
    rsp_valid_d = 1'b0;
    rdata_d     = rdata_q;
    err_d       = err_q;
`ifdef DBUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (lsu_req_valid_i) begin
          if (dec_hit) begin
            state_d       = REQ;
            dbus_d.req    = 1'b1;
            dbus_d.addr   = lsu_addr_i;
            dbus_d.w_data = lsu_wdata_i;
            dbus_d.w_en   = lsu_we_i;
            sel_d         = dec_sel;
            idx_d         = dec_idx;
`ifdef DBUS_TIMEOUT_EN
            cnt_d         = '0;
`endif
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rdata_d     = '0;
            err_d       = 1'b1;
          end
        end
      end
      REQ: begin
        if (peri_ack) begin
          state_d     = RESP;
          dbus_d.req  = 1'b0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rdata_d     = dbus_q.w_en ? 32'h0 : peri_rdata;
          err_d       = 1'b0;
        end
`ifdef DBUS_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d     = RESP;
          dbus_d.req  = 1'b0;
          sel_d       = '0;
          rsp_valid_d = 1'b1;
          rdata_d     = '0;
          err_d       = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      RESP: begin
        state_d = IDLE;
        rdata_d = '0;
        err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      dbus_q      <= '0;
      sel_q       <= '0;
      idx_q       <= '0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
`ifdef DBUS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      dbus_q      <= dbus_d;
      sel_q       <= sel_d;
      idx_q       <= idx_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef DBUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign lsu_req_ready_o = (state_q == IDLE);
  assign lsu_rsp_valid_o = rsp_valid_q;
  assign lsu_rdata_o     = rdata_q;
  assign lsu_rsp_err_o   = err_q;
  assign dbus2peri_o     = dbus_q;
  assign peri_sel_o      = sel_q;

endmodule

// File: tb/tb_dbus_peri_initiator.sv
// Bench for dbus_peri_initiator: GPIO-style responders on four slots, directed vector table,
// randomized traffic against a behavioural model, and multi-cycle corner sequences.
`timescale 1ns/1ps
module tb_dbus_peri_initiator;
  import dbus_peri_initiator_pkg::*;

  localparam int          NP   = 4;
  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int          TO   = 16;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            lsu_valid = 1'b0;
  logic            ready;
  logic [31:0]     lsu_addr = '0;
  logic [31:0]     lsu_wdata = '0;
  logic            lsu_we = 1'b0;
  logic            rsp_valid;
  logic [31:0]     rdata;
  logic            err;
  type_dbus2peri_s dbus;
  logic [NP-1:0]   sel;
  type_peri2dbus_s p2d [NP];

  always #5 clk = ~clk;

  dbus_peri_initiator #(
    .NUM_PERI      (NP),
    .PERI_BASE     (BASE),
    .PERI_SPAN_LOG2(8),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .lsu_req_valid_i(lsu_valid),
    .lsu_req_ready_o(ready),
    .lsu_addr_i     (lsu_addr),
    .lsu_wdata_i    (lsu_wdata),
    .lsu_we_i       (lsu_we),
    .lsu_rsp_valid_o(rsp_valid),
    .lsu_rdata_o    (rdata),
    .lsu_rsp_err_o  (err),
    .dbus2peri_o    (dbus),
    .peri_sel_o     (sel),
    .peri2dbus_i    (p2d)
  );

  // Read data a slot returns for a given address.
  function automatic logic [31:0] peri_word(input int slot, input logic [31:0] a);
    logic [7:0] lo;
    lo = a[7:0];
    if (slot == 2 && lo == 8'h00) return 32'hDEAD_BEEF;
    return {4'hA, 4'(slot), 16'h5A5A, lo};
  endfunction

  // Responders: ack one cycle after seeing req+sel, never re-ack while ack is high.
  bit          silent   [NP];
  bit          spurious [NP];
  logic        ack_r    [NP];
  logic [31:0] rdat_r   [NP];
  logic [31:0] last_wr_data [NP];
  int          wr_cnt   [NP];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NP; i++) begin
        ack_r[i] <= 1'b0; rdat_r[i] <= '0; wr_cnt[i] <= 0; last_wr_data[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NP; i++) begin
        if (spurious[i]) begin
          ack_r[i]  <= ~ack_r[i];
          rdat_r[i] <= 32'hBAD0_0000;
        end else if (!silent[i] && dbus.req && sel[i] && !ack_r[i]) begin
          ack_r[i] <= 1'b1;
          if (dbus.w_en) begin
            rdat_r[i]       <= '0;
            last_wr_data[i] <= dbus.w_data;
            wr_cnt[i]       <= wr_cnt[i] + 1;
          end else begin
            rdat_r[i] <= peri_word(i, dbus.addr);
          end
        end else begin
          ack_r[i] <= 1'b0;
        end
      end
    end
  end

  for (genvar gi = 0; gi < NP; gi++) begin : g_p2d
    assign p2d[gi].ack    = ack_r[gi];
    assign p2d[gi].r_data = rdat_r[gi];
  end

  int n_run  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
    end
  endtask

  function automatic int wr_total();
    int s = 0;
    for (int i = 0; i < NP; i++) s += wr_cnt[i];
    return s;
  endfunction

  // Behavioural reference: range check on the address, slot by window arithmetic.
  function automatic void model(input logic [31:0] a, input logic we, output bit hit,
                                output int slot, output logic [31:0] rd, output logic er,
                                output int lat);
    longint la, lb;
    la   = longint'(a);
    lb   = longint'(BASE);
    hit  = (la >= lb) && (la < lb + NP * 256);
    slot = hit ? int'((la - lb) / 256) : 0;
    er   = !hit;
    rd   = (hit && !we) ? peri_word(slot, a) : 32'h0;
    lat  = hit ? 3 : 1;
  endfunction

  // One transfer: drive at a negedge, accept at the next posedge (c0), observe until rsp_valid.
  task automatic run_txn(input logic [31:0] a, input logic [31:0] wd, input logic we,
                         input int budget, output int lat, output logic [31:0] rd,
                         output logic er, output logic [NP-1:0] sel_seen, output int req_cyc,
                         output int acks, output bit held_ok);
    lat = -1; rd = '0; er = 1'b0; sel_seen = '0; req_cyc = 0; acks = 0; held_ok = 1'b1;
    @(negedge clk);
    check("ready_before_req", ready, 1'b1);
    lsu_valid = 1'b1; lsu_addr = a; lsu_wdata = wd; lsu_we = we;
    @(posedge clk);
    #1;
    lsu_valid = 1'b0; lsu_addr = $urandom; lsu_wdata = $urandom; lsu_we = 1'($urandom);
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (dbus.req) begin
        req_cyc++;
        sel_seen |= sel;
        if (dbus.addr !== a || dbus.w_data !== wd || dbus.w_en !== we) held_ok = 1'b0;
      end
      for (int i = 0; i < NP; i++) if (!spurious[i] && p2d[i].ack) acks++;
      if (rsp_valid) begin
        lat = c; rd = rdata; er = err;
        break;
      end
    end
    $display("[TB] txn addr=0x%08h we=%0d wdata=0x%08h -> rdata=0x%08h err=%0d lat=%0d req_cycles=%0d",
             a, we, wd, rd, er, lat, req_cyc);
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [3:0]  exp_sel;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_req;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t          vecs [8];
    int            lat, req_cyc, acks, wr0, slot, mlat, acc2, rdy_cnt, rsp_cnt, req_cnt;
    logic [31:0]   rd, mrd, a, wd;
    logic          er, mer, we;
    logic [NP-1:0] sel_seen;
    bit            held_ok, hit;
    int            rc[$];
    logic [31:0]   rdq[$];
    logic          erq[$];

    for (int i = 0; i < NP; i++) begin silent[i] = 1'b0; spurious[i] = 1'b0; end

    vecs[0] = '{32'h8000_0104, 32'h0000_00A5, 1'b1, 4'b0010, 32'h0000_0000, 1'b0, 3, 2};
    vecs[1] = '{32'h8000_0200, 32'h0000_0000, 1'b0, 4'b0100, 32'hDEAD_BEEF, 1'b0, 3, 2};
    vecs[2] = '{32'h8000_0400, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1, 0};
    vecs[3] = '{32'h8000_0000, 32'h0000_0000, 1'b0, 4'b0001, 32'hA05A_5A00, 1'b0, 3, 2};
    vecs[4] = '{32'h8000_03FC, 32'h0000_0000, 1'b0, 4'b1000, 32'hA35A_5AFC, 1'b0, 3, 2};
    vecs[5] = '{32'h7FFF_FFFC, 32'h0000_0000, 1'b0, 4'b0000, 32'h0000_0000, 1'b1, 1, 0};
    vecs[6] = '{32'hFFFF_FFFF, 32'h1111_2222, 1'b1, 4'b0000, 32'h0000_0000, 1'b1, 1, 0};
    vecs[7] = '{32'h8000_0010, 32'h1234_5678, 1'b1, 4'b0001, 32'h0000_0000, 1'b0, 3, 2};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", ready, 1'b1);
    check("rst_req", dbus.req, 1'b0);
    check("rst_sel", sel, '0);
    check("rst_rsp_valid", rsp_valid, 1'b0);
    check("rst_rdata", rdata, '0);
    check("rst_err", err, 1'b0);

    // Directed vectors
    for (int k = 0; k < 8; k++) begin
      wr0 = wr_total();
      run_txn(vecs[k].addr, vecs[k].wdata, vecs[k].we, 40, lat, rd, er, sel_seen, req_cyc, acks, held_ok);
      check($sformatf("vec%0d_lat", k), lat, vecs[k].exp_lat);
      check($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rdata);
      check($sformatf("vec%0d_err", k), er, vecs[k].exp_err);
      check($sformatf("vec%0d_sel", k), sel_seen, vecs[k].exp_sel);
      check($sformatf("vec%0d_req_cycles", k), req_cyc, vecs[k].exp_req);
      check($sformatf("vec%0d_acks", k), acks, (vecs[k].exp_sel != 0) ? 1 : 0);
      check($sformatf("vec%0d_held", k), held_ok, 1'b1);
      check($sformatf("vec%0d_writes", k), wr_total() - wr0,
            (vecs[k].we && vecs[k].exp_sel != 0) ? 1 : 0);
      if (vecs[k].we && vecs[k].exp_sel != 0)
        check($sformatf("vec%0d_wdata_at_slot", k), last_wr_data[$clog2(vecs[k].exp_sel)], vecs[k].wdata);
    end

    // Randomized traffic against the model
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 3))
        0, 1:    a = BASE + 32'($urandom_range(0, NP - 1) << 8) + 32'($urandom_range(0, 63) << 2);
        2:       a = BASE + 32'(NP * 256) + 32'($urandom_range(0, 255));
        default: a = $urandom;
      endcase
      we = 1'($urandom);
      wd = $urandom;
      model(a, we, hit, slot, mrd, mer, mlat);
      wr0 = wr_total();
      run_txn(a, wd, we, 40, lat, rd, er, sel_seen, req_cyc, acks, held_ok);
      check("rnd_lat", lat, mlat);
      check("rnd_rdata", rd, mrd);
      check("rnd_err", er, mer);
      check("rnd_sel", sel_seen, hit ? (NP'(1) << slot) : '0);
      check("rnd_acks", acks, hit ? 1 : 0);
      check("rnd_held", held_ok, 1'b1);
      check("rnd_writes", wr_total() - wr0, (hit && we) ? 1 : 0);
      if (hit && we) check("rnd_wdata_at_slot", last_wr_data[slot], wd);
    end

    // Valid held across two reads; slot3 chatters with unsolicited acks
    spurious[3] = 1'b1;
    acc2 = -1;
    @(negedge clk);
    check("t5_ready_first", ready, 1'b1);
    lsu_valid = 1'b1; lsu_addr = BASE + 32'h008; lsu_we = 1'b0; lsu_wdata = '0;
    @(posedge clk);
    #1;
    lsu_addr = BASE + 32'h10C;
    for (int c = 1; c <= 15; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        rc.push_back(c); rdq.push_back(rdata); erq.push_back(err);
        $display("[TB] txn b2b response at c%0d rdata=0x%08h err=%0d", c, rdata, err);
      end
      if (lsu_valid && ready && acc2 < 0) begin
        acc2 = c;
        @(posedge clk);
        #1;
        lsu_valid = 1'b0;
      end
    end
    spurious[3] = 1'b0;
    check("t5_second_accept", acc2, 4);
    check("t5_num_rsp", rc.size(), 2);
    check("t5_rsp0_cycle", (rc.size() > 0) ? rc[0] : -1, 3);
    check("t5_rsp1_cycle", (rc.size() > 1) ? rc[1] : -1, 7);
    check("t5_rsp0_rdata", (rdq.size() > 0) ? rdq[0] : 32'hFFFF_FFFF, 32'hA05A_5A08);
    check("t5_rsp1_rdata", (rdq.size() > 1) ? rdq[1] : 32'hFFFF_FFFF, 32'hA15A_5A0C);
    check("t5_rsp0_err", (erq.size() > 0) ? erq[0] : 1'b1, 1'b0);
    check("t5_rsp1_err", (erq.size() > 1) ? erq[1] : 1'b1, 1'b0);
    repeat (3) @(negedge clk);

    // Silent slot3
    silent[3] = 1'b1;
`ifdef DBUS_TIMEOUT_EN
    run_txn(BASE + 32'h300, 32'h0, 1'b0, 40, lat, rd, er, sel_seen, req_cyc, acks, held_ok);
    check("t4_timeout_lat", lat, TO + 1);
    check("t4_timeout_req_cycles", req_cyc, TO);
    check("t4_timeout_err", er, 1'b1);
    check("t4_timeout_rdata", rd, 32'h0);
    check("t4_timeout_sel", sel_seen, 4'b1000);
    @(negedge clk);
    check("t4_ready_after", ready, 1'b1);
    lsu_valid = 1'b1; lsu_addr = BASE + 32'h304; lsu_we = 1'b0;
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
    @(negedge clk);
`else
    rdy_cnt = 0; rsp_cnt = 0; req_cnt = 0;
    @(negedge clk);
    lsu_valid = 1'b1; lsu_addr = BASE + 32'h300; lsu_we = 1'b0;
    @(posedge clk);
    #1;
    lsu_valid = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (ready) rdy_cnt++;
      if (rsp_valid) rsp_cnt++;
      if (dbus.req) req_cnt++;
    end
    $display("[TB] txn silent slot3: ready cycles=%0d rsp=%0d req cycles=%0d", rdy_cnt, rsp_cnt, req_cnt);
    check("t4_ready_stays_low", rdy_cnt, 0);
    check("t4_no_response", rsp_cnt, 0);
    check("t4_req_held", req_cnt, 100);
`endif

    // Asynchronous reset in the middle of REQ
    check("t6_req_before_reset", dbus.req, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_req_async", dbus.req, 1'b0);
    check("t6_sel_async", sel, '0);
    check("t6_rsp_valid_async", rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    silent[3] = 1'b0;
    rsp_cnt = 0;
    @(negedge clk);
    check("t6_ready_after_release", ready, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_cnt++;
    end
    check("t6_no_response", rsp_cnt, 0);
    $display("[TB] txn reset-during-REQ: dropped, ready=%0d", ready);

    run_txn(32'h8000_0204, 32'h0, 1'b0, 40, lat, rd, er, sel_seen, req_cyc, acks, held_ok);
    check("t6_post_reset_rdata", rd, 32'hA25A_5A04);
    check("t6_post_reset_lat", lat, 3);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
